product_table_streamer: RTL and testbench



---
 rtl/product_table_pkg.sv | 14 +
 rtl/product_table_regs.sv | 35 +++
 rtl/product_table_streamer.sv | 126 ++++++++++++
 tb/tb_product_table_streamer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/product_table_pkg.sv
// product_table_pkg: shared state encoding and width helpers for product_table_streamer.
package product_table_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

    function automatic int idx_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    function automatic int prod_w(input int iw, input int sw);
        return 2 * iw + sw;
    endfunction

endpackage

// File: rtl/product_table_regs.sv
// product_table_regs: generate-built N x N table of i*j*scale, parallel load, (row, col) read mux.
// Instantiated only when PRODUCT_TABLE_STREAMER_REGS_EN is defined.
module product_table_regs
    import product_table_pkg::*;
#(
    parameter int N = 5,
    parameter int SCALE_W = 8,
    localparam int IDX_W = idx_w(N),
    localparam int PROD_W = prod_w(IDX_W, SCALE_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [SCALE_W-1:0] scale_i,
    input  logic [IDX_W-1:0]   row_i,
    input  logic [IDX_W-1:0]   col_i,
    output logic [PROD_W-1:0]  prod_o
);

    logic [PROD_W-1:0] tbl [N][N];

    for (genvar i = 0; i < N; i++) begin : FOR_ROW
        for (genvar j = 0; j < N; j++) begin : FOR_COL
            logic [PROD_W-1:0] ent_q;
            always_ff @(posedge clk) begin
                if (rst) ent_q <= '0;
                else if (load_i) ent_q <= PROD_W'(i * j) * PROD_W'(scale_i);
            end
            assign tbl[i][j] = ent_q;
        end
    end

    assign prod_o = tbl[row_i][col_i];

endmodule

// File: rtl/product_table_streamer.sv
// product_table_streamer: walks an N x N product table row-major, emitting i*j*scale on a valid/ready stream.
// PRODUCT_TABLE_STREAMER_REGS_EN selects a preloaded register table (one extra cycle of start latency).
module product_table_streamer
    import product_table_pkg::*;
#(
    parameter int N = 5,
    parameter int SCALE_W = 8,
    localparam int IDX_W = idx_w(N),
    localparam int PROD_W = prod_w(IDX_W, SCALE_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SCALE_W-1:0] scale,
    output logic               busy,
    output logic               done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_i,
    output logic [IDX_W-1:0]   out_j,
    output logic [PROD_W-1:0]  out_prod
);

    state_t               state_q, state_d;
    logic [SCALE_W-1:0]   scale_q, scale_d;
    logic                 busy_q, busy_d, done_q, done_d, vld_q, vld_d;
    logic [IDX_W-1:0]     i_q, i_d, j_q, j_d, ni, nj;
    logic [PROD_W-1:0]    prod_q, prod_d, nprod;
    logic                 row_end, last, xfer;

    assign row_end = j_q == IDX_W'(N - 1);
    assign last    = row_end && (i_q == IDX_W'(N - 1));
    assign xfer    = vld_q && out_ready;
    assign nj      = row_end ? '0 : j_q + 1'b1;
    assign ni      = row_end ? i_q + 1'b1 : i_q;

`ifdef PRODUCT_TABLE_STREAMER_REGS_EN
    product_table_regs #(.N(N), .SCALE_W(SCALE_W)) u_regs (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q == LOAD),
        .scale_i(scale_q),
        .row_i  (ni),
        .col_i  (nj),
        .prod_o (nprod)
    );
`else
    assign nprod = PROD_W'(ni) * PROD_W'(nj) * PROD_W'(scale_q);
`endif

    always_comb begin
        state_d = state_q;
        scale_d = scale_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        vld_d   = vld_q;
        i_d     = i_q;
        j_d     = j_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: if (start) begin
                scale_d = scale;
                busy_d  = 1'b1;
                i_d     = '0;
                j_d     = '0;
                prod_d  = '0;
`ifdef PRODUCT_TABLE_STREAMER_REGS_EN
                state_d = LOAD;
`else
                state_d = STREAM;
                vld_d   = 1'b1;
`endif
            end
`ifdef PRODUCT_TABLE_STREAMER_REGS_EN
            LOAD: begin
                state_d = STREAM;
                vld_d   = 1'b1;
            end
`endif
            STREAM: if (xfer) begin
                if (last) begin
                    state_d = DONE;
                    vld_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    i_d    = ni;
                    j_d    = nj;
                    prod_d = nprod;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            scale_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            scale_q <= scale_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
            i_q     <= i_d;
            j_q     <= j_d;
            prod_q  <= prod_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = vld_q;
    assign out_i     = i_q;
    assign out_j     = j_q;
    assign out_prod  = prod_q;

endmodule

// File: tb/tb_product_table_streamer.sv
// tb_product_table_streamer: directed passes (full, backpressure, max scale, ignored start, mid-stream reset).
module tb_product_table_streamer;

    localparam int N = 5;
`ifdef PRODUCT_TABLE_STREAMER_REGS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst, start, out_ready;
    logic [7:0]  scale;
    logic        busy, done, out_valid;
    logic [2:0]  out_i, out_j;
    logic [13:0] out_prod;
    int          checks = 0;
    int          failures = 0;

    product_table_streamer #(.N(N), .SCALE_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .scale    (scale),
        .busy     (busy),
        .done     (done),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_i    (out_i),
        .out_j    (out_j),
        .out_prod (out_prod)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // mode 0: ready high; 1: toggling ready plus 4-cycle stall at (1,2);
    // 2: start/scale poked mid-stream and in DONE; 3: reset after 7 beats
    task automatic run_pass(input logic [7:0] sc, input int mode, output int nbeats,
                            output int first_n, output int done_n, output int npulse,
                            output logic [31:0] p23, output logic [31:0] p44);
        int ei, ej, stalls;
        ei = 0; ej = 0; stalls = 0; nbeats = 0; first_n = -1; done_n = -1; npulse = 0;
        p23 = 0; p44 = 0;
        start = 1'b1; scale = sc; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 150; n++) begin
            if (mode == 3 && nbeats == 7) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_valid", out_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_i", out_i, 0);
                check("rst_j", out_j, 0);
                check("rst_prod", out_prod, 0);
                return;
            end
            if (mode == 2) begin
                start = (n == 10) || done;
                scale = (n >= 10) ? 8'd9 : sc;
            end
            if (done) begin
                npulse++;
                if (done_n < 0) done_n = n;
            end
            if (done_n > 0 && n > done_n) check("post_idle", {30'd0, out_valid, busy}, 0);
            if (out_valid && first_n < 0) first_n = n;
            if (mode == 1) begin
                if (out_valid && ei == 1 && ej == 2 && stalls < 4) begin
                    out_ready = 1'b0;
                    stalls++;
                    check("stall_prod", out_prod, 6);
                end else out_ready = (n % 2) == 1;
            end else out_ready = 1'b1;
            if (out_valid) begin
                check("beat_i", out_i, ei);
                check("beat_j", out_j, ej);
                check("beat_prod", out_prod, ei * ej * sc);
                if (out_ready) begin
                    if (ei == 2 && ej == 3) p23 = out_prod;
                    if (ei == 4 && ej == 4) p44 = out_prod;
                    nbeats++;
                    if (ej == N - 1) begin
                        ej = 0;
                        ei++;
                    end else ej++;
                end
            end
            if (done_n > 0 && n >= done_n + 3) break;
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (done_n < 0) check("done_timeout", 0, 1);
    endtask

    initial begin
        int nb, fn, dn, np;
        logic [31:0] p23, p44;
        rst = 1'b1; start = 1'b0; scale = 8'd0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_valid", out_valid, 0);
        check("reset_i", out_i, 0);
        check("reset_j", out_j, 0);
        check("reset_prod", out_prod, 0);
        rst = 1'b0;
        @(negedge clk);

        run_pass(8'd1, 0, nb, fn, dn, np, p23, p44);
        check("full_beats", nb, 25);
        check("full_first", fn, LAT);
        check("full_done_at", dn, 25 + LAT);
        check("full_pulses", np, 1);
        check("full_p23", p23, 6);
        check("full_p44", p44, 16);

        run_pass(8'd3, 1, nb, fn, dn, np, p23, p44);
        check("bp_beats", nb, 25);
        check("bp_pulses", np, 1);
        check("bp_p44", p44, 48);

        run_pass(8'd255, 0, nb, fn, dn, np, p23, p44);
        check("max_p44", p44, 4080);
        check("max_p23", p23, 1530);
        check("max_done_at", dn, 25 + LAT);

        run_pass(8'd5, 2, nb, fn, dn, np, p23, p44);
        check("ign_beats", nb, 25);
        check("ign_done_at", dn, 25 + LAT);
        check("ign_pulses", np, 1);
        check("ign_p44", p44, 80);

        run_pass(8'd3, 3, nb, fn, dn, np, p23, p44);
        check("rst_beats", nb, 7);

        run_pass(8'd2, 0, nb, fn, dn, np, p23, p44);
        check("restart_beats", nb, 25);
        check("restart_first", fn, LAT);
        check("restart_p23", p23, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
